// File: rtl/collision_pair_scheduler_if.sv
// Request/result handshake between the pair scheduler and the shared collision engine.
interface collision_pair_scheduler_if #(
    parameter int IDX_W = 4
);
    logic             pairValid;
    logic [IDX_W-1:0] pairIdxA;
    logic [IDX_W-1:0] pairIdxB;
    logic             pairReady;
    logic             resultValid;
    logic             resultHit;

    modport master (
        output pairValid, pairIdxA, pairIdxB,
        input  pairReady, resultValid, resultHit
    );

    modport slave (
        input  pairValid, pairIdxA, pairIdxB,
        output pairReady, resultValid, resultHit
    );
endinterface

// File: rtl/collision_pair_scheduler.sv
// Walks every ball pair (i<j) once per frame, sharing one collision engine among them.
// Optional PAIR_COOLDOWN_EN: a pair that hit is skipped once in the following scan.
module collision_pair_scheduler #(
    parameter int NUM_BALLS = 16,
    parameter int IDX_W     = $clog2(NUM_BALLS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frameStart,
    input  logic [NUM_BALLS-1:0]       ballActive,
    collision_pair_scheduler_if.master eng,
    output logic                       busy,
    output logic                       frameDone,
    output logic [7:0]                 hitCount,
    output logic                       overrun
);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BALLS - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(NUM_BALLS - 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, nextState;

    logic [IDX_W-1:0]     idxA, idxB, nextA, nextB;
    logic [NUM_BALLS-1:0] snapshot, nextSnapshot;
    logic                 pairValid, pairValidNext, busyNext, frameDoneNext;
    logic                 advance, accept, hitSeen, pairEligibleNext;
    logic [7:0]           hitCountNext;

`ifdef PAIR_COOLDOWN_EN
    localparam int NUM_PAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;
    localparam int PAIR_W    = $clog2(NUM_PAIRS + 1);
    logic [NUM_PAIRS-1:0] cooldown, nextCooldown;
    logic [PAIR_W-1:0]    pairNum, nextPairNum;
`endif

    assign accept  = (state == IDLE) && frameStart;
    assign hitSeen = (state == WAIT) && eng.resultValid && eng.resultHit;

    assign eng.pairValid = pairValid;
    assign eng.pairIdxA  = idxA;
    assign eng.pairIdxB  = idxB;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The registered pairValid doubles as "current pair is eligible" while in ISSUE.
    always_comb begin
        nextState = state;
        nextA     = idxA;
        nextB     = idxB;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (frameStart) begin
                    nextState = ISSUE;
                    nextA     = '0;
                    nextB     = IDX_W'(1);
                end
            end
            ISSUE: begin
                if (!pairValid) begin
                    advance = 1'b1;
                end else if (eng.pairReady) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (eng.resultValid) begin
                    advance = 1'b1;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (advance) begin
            nextState = ISSUE;
            if (idxB != LAST_IDX) begin
                nextB = idxB + IDX_W'(1);
            end else if (idxA != PENULT_IDX) begin
                nextA = idxA + IDX_W'(1);
                nextB = idxA + IDX_W'(2);
            end else begin
                nextState = DONE;
            end
        end
    end

    always_comb begin
        nextSnapshot = accept ? ballActive : snapshot;
        hitCountNext = hitCount;
        if (accept) begin
            hitCountNext = '0;
        end else if (hitSeen && hitCount != 8'hFF) begin
            hitCountNext = hitCount + 8'd1;
        end
`ifdef PAIR_COOLDOWN_EN
        nextCooldown = cooldown;
        nextPairNum  = pairNum;
        if (accept) begin
            nextPairNum = '0;
        end else if (advance && nextState == ISSUE) begin
            nextPairNum = pairNum + PAIR_W'(1);
        end
        if (state == ISSUE && !pairValid) begin
            nextCooldown[pairNum] = 1'b0;
        end
        if (hitSeen) begin
            nextCooldown[pairNum] = 1'b1;
        end
`endif
    end

    // Outputs are computed one cycle ahead from next-state values so they leave flops.
    always_comb begin
        busyNext         = (nextState != IDLE);
        frameDoneNext    = (nextState == DONE);
        pairEligibleNext = nextSnapshot[nextA] && nextSnapshot[nextB];
`ifdef PAIR_COOLDOWN_EN
        if (nextCooldown[nextPairNum]) begin
            pairEligibleNext = 1'b0;
        end
`endif
        pairValidNext = (nextState == ISSUE) && pairEligibleNext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idxA      <= '0;
            idxB      <= IDX_W'(1);
            snapshot  <= '0;
            pairValid <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
            hitCount  <= '0;
            overrun   <= 1'b0;
`ifdef PAIR_COOLDOWN_EN
            cooldown  <= '0;
            pairNum   <= '0;
`endif
        end else begin
            idxA      <= nextA;
            idxB      <= nextB;
            snapshot  <= nextSnapshot;
            pairValid <= pairValidNext;
            busy      <= busyNext;
            frameDone <= frameDoneNext;
            hitCount  <= hitCountNext;
            overrun   <= overrun | (frameStart && state != IDLE);
`ifdef PAIR_COOLDOWN_EN
            cooldown  <= nextCooldown;
            pairNum   <= nextPairNum;
`endif
        end
    end
endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Directed scans on a 4-ball scheduler with an engine model and a pair-order scoreboard.
module tb_collision_pair_scheduler;
    localparam int N            = 4;
    localparam int IW           = 2;
    localparam int STALL_CYCLES = 5;
    localparam int SCAN_LIMIT   = 200;

    logic         clk = 1'b0;
    logic         reset;
    logic         frameStart;
    logic [N-1:0] ballActive;
    logic         busy;
    logic         frameDone;
    logic [7:0]   hitCount;
    logic         overrun;

    int           assertions = 0;
    int           failures   = 0;
    logic [3:0]   expPairs[$];
    logic [15:0]  hitTable;

    collision_pair_scheduler_if #(.IDX_W(IW)) bus ();

    collision_pair_scheduler #(.NUM_BALLS(N), .IDX_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .frameStart (frameStart),
        .ballActive (ballActive),
        .eng        (bus),
        .busy       (busy),
        .frameDone  (frameDone),
        .hitCount   (hitCount),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pairValid"}, 32'(bus.pairValid), 32'd0);
        checkOutput({tag, "_pairIdxA"},  32'(bus.pairIdxA),  32'd0);
        checkOutput({tag, "_pairIdxB"},  32'(bus.pairIdxB),  32'd1);
        checkOutput({tag, "_busy"},      32'(busy),          32'd0);
        checkOutput({tag, "_frameDone"}, 32'(frameDone),     32'd0);
        checkOutput({tag, "_hitCount"},  32'(hitCount),      32'd0);
        checkOutput({tag, "_overrun"},   32'(overrun),       32'd0);
    endtask

    // Expected issue order: all i<j pairs with both balls active, minus any skipped ones.
    task automatic pushPairs(input logic [3:0] active, input logic [15:0] skip);
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                logic [3:0] key;
                key = {2'(i), 2'(j)};
                if (active[i] && active[j] && !skip[key]) expPairs.push_back(key);
            end
        end
    endtask

    // Pulses frameStart and then acts as the engine every negedge until frameDone or stopAt.
    task automatic applyStimulus(input string tag, input logic [3:0] active, input int expCycles,
                                 input int expFirst, input int expHits, input int pokeAt,
                                 input bit stallOn, input int stopAt);
        int         cycles     = 0;
        int         firstValid = -1;
        bit         done       = 1'b0;
        bit         pending    = 1'b0;
        int         engDelay   = 0;
        int         stallLeft  = 0;
        bit         stallUsed  = 1'b0;
        logic [3:0] pendKey    = '0;
        ballActive = active;
        frameStart = 1'b1;
        @(negedge clk);
        for (int k = 0; k < SCAN_LIMIT && !done; k++) begin
            if (busy) cycles++;
            if (k == 0) checkOutput({tag, "_hitClear"}, 32'(hitCount), 32'd0);
            if (firstValid < 0 && bus.pairValid === 1'b1) firstValid = cycles;
            frameStart       = (cycles == pokeAt);
            bus.resultValid  = 1'b0;
            bus.resultHit    = 1'b0;
            bus.pairReady    = 1'b1;
            if (pending) begin
                if (engDelay <= 1) begin
                    bus.resultValid = 1'b1;
                    bus.resultHit   = hitTable[pendKey];
                    pending         = 1'b0;
                end else begin
                    engDelay--;
                end
            end
            if (bus.pairValid === 1'b1) begin
                if (stallOn && !stallUsed && bus.pairIdxA == 2'd0 && bus.pairIdxB == 2'd2) begin
                    stallUsed = 1'b1;
                    stallLeft = STALL_CYCLES;
                end
                if (stallLeft > 0) begin
                    if (stallLeft < STALL_CYCLES)
                        checkOutput({tag, "_stallHold"}, 32'({bus.pairIdxA, bus.pairIdxB}), 32'h2);
                    bus.pairReady = 1'b0;
                    stallLeft--;
                end else begin
                    checkOutput({tag, "_sbNonEmpty"}, 32'(expPairs.size() > 0), 32'd1);
                    if (expPairs.size() > 0)
                        checkOutput({tag, "_pairOrder"}, 32'({bus.pairIdxA, bus.pairIdxB}),
                                    32'(expPairs.pop_front()));
                    pendKey  = {bus.pairIdxA, bus.pairIdxB};
                    pending  = 1'b1;
                    engDelay = 2;
                end
            end else if (stallLeft > 0) begin
                checkOutput({tag, "_stallValid"}, 32'(bus.pairValid), 32'd1);
                stallLeft = 0;
            end
            if (cycles == stopAt) done = 1'b1;
            else if (frameDone === 1'b1) done = 1'b1;
            else @(negedge clk);
        end
        frameStart = 1'b0;
        checkOutput({tag, "_finished"}, 32'(done), 32'd1);
        if (stopAt < 0) begin
            checkOutput({tag, "_cycles"},     32'(cycles),     32'(expCycles));
            checkOutput({tag, "_firstValid"}, 32'(firstValid), 32'(expFirst));
            checkOutput({tag, "_hitCount"},   32'(hitCount),   32'(expHits));
            @(negedge clk);
            bus.resultValid = 1'b0;
            checkOutput({tag, "_donePulse"},  32'(frameDone),       32'd0);
            checkOutput({tag, "_idleBusy"},   32'(busy),            32'd0);
            checkOutput({tag, "_sbEmpty"},    32'(expPairs.size()), 32'd0);
            checkOutput({tag, "_hitHold"},    32'(hitCount),        32'(expHits));
        end
    endtask

    initial begin
        reset           = 1'b1;
        frameStart      = 1'b0;
        ballActive      = '0;
        hitTable        = '0;
        bus.pairReady   = 1'b1;
        bus.resultValid = 1'b0;
        bus.resultHit   = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] scan: all active, 5-cycle stall on (0,2)");
        pushPairs(4'hF, 16'h0);
        applyStimulus("allStall", 4'hF, 18 + 1 + STALL_CYCLES, 1, 0, -1, 1'b1, -1);

        $display("[TB] scan: ball 1 inactive");
        pushPairs(4'b1101, 16'h0);
        applyStimulus("ball1Off", 4'b1101, 13, 2, 0, -1, 1'b0, -1);

        $display("[TB] scan: hits on (0,1) and (2,3)");
        hitTable[4'h1] = 1'b1;
        hitTable[4'hB] = 1'b1;
        pushPairs(4'hF, 16'h0);
        applyStimulus("twoHits", 4'hF, 19, 1, 2, -1, 1'b0, -1);

`ifdef PAIR_COOLDOWN_EN
        pushPairs(4'hF, 16'h0802);
        applyStimulus("cooldown", 4'hF, 15, 2, 0, -1, 1'b0, -1);
`else
        pushPairs(4'hF, 16'h0);
        applyStimulus("noCooldown", 4'hF, 19, 1, 2, -1, 1'b0, -1);
`endif
        hitTable = '0;
        pushPairs(4'hF, 16'h0);
        applyStimulus("allSixAgain", 4'hF, 19, 1, 0, -1, 1'b0, -1);

        $display("[TB] scan: frameStart during WAIT");
        checkOutput("overrunBefore", 32'(overrun), 32'd0);
        pushPairs(4'hF, 16'h0);
        applyStimulus("overrun", 4'hF, 19, 1, 0, 2, 1'b0, -1);
        checkOutput("overrunSet", 32'(overrun), 32'd1);

        $display("[TB] scan: reset during WAIT on (1,2)");
        hitTable[4'h1] = 1'b1;
        expPairs.push_back(4'h1);
        expPairs.push_back(4'h2);
        expPairs.push_back(4'h3);
        expPairs.push_back(4'h6);
        applyStimulus("midReset", 4'hF, 0, 0, 0, -1, 1'b0, 11);
        checkOutput("midReset_preHits",    32'(hitCount),      32'd1);
        checkOutput("midReset_preOverrun", 32'(overrun),       32'd1);
        checkOutput("midReset_preValid",   32'(bus.pairValid), 32'd0);
        checkOutput("midReset_preIdxB",    32'(bus.pairIdxB),  32'd2);
        reset = 1'b1;
        #1;
        checkResetValues("midReset");
        checkOutput("midReset_sbEmpty", 32'(expPairs.size()), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        hitTable = '0;
        @(negedge clk);

        pushPairs(4'hF, 16'h0);
        applyStimulus("restart", 4'hF, 19, 1, 0, -1, 1'b0, -1);
        checkOutput("overrunCleared", 32'(overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/collision_pair_scheduler.md
# collision_pair_scheduler

Per-frame scheduler that shares one pairwise ball-collision engine among `NUM_BALLS` balls. Starting on each frame-start pulse, it walks every unordered ball pair (i<j) in fixed order. For each pair where both balls are active, it issues one request to the engine, waits for the engine's result, and counts hits. It sits in the hit-controller between the frame timing logic and the shared collision datapath, and drives that datapath's ball-select muxes.

## Interface
Parameters:
- `NUM_BALLS`, default 16: number of balls; legal range 2..32.
- `IDX_W`, default `$clog2(NUM_BALLS)`: width of the ball index outputs.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `frameStart`  in  1  one-cycle pulse that starts a scan.
- `ballActive`  in  NUM_BALLS  per-ball enable (0 = pocketed); snapshotted at scan start.
- `pairValid`  out  1  request to engine; pair indices are valid.
- `pairIdxA`  out  IDX_W  lower ball index i.
- `pairIdxB`  out  IDX_W  higher ball index j.
- `pairReady`  in  1  engine accepts the request.
- `resultValid`  in  1  one-cycle pulse; engine finished the accepted pair.
- `resultHit`  in  1  collision flag, qualified by `resultValid`.
- `busy`  out  1  high from the cycle after an accepted `frameStart` through the `DONE` cycle.
- `frameDone`  out  1  one-cycle pulse when the scan completes.
- `hitCount`  out  8  collisions in the current/last scan; saturates at 255.
- `overrun`  out  1  sticky; a `frameStart` arrived while `busy`.

## Operation
States: `IDLE`, `ISSUE`, `WAIT`, `DONE`.
- **`IDLE`**: on `frameStart`:
  - latch `ballActive` into the snapshot;
  - clear `hitCount`;
  - set pair (0,1);
  - go to `ISSUE`.
- **`ISSUE`**:
  - Pair ineligible (either ball inactive in the snapshot, or cooldown-masked): `pairValid`=0 and advance the pair. This costs exactly one cycle per skipped pair.
  - Pair eligible: assert `pairValid`. Indices stay stable while `pairValid`=1 and `pairReady`=0. On `pairValid && pairReady`, go to `WAIT`.
- **`WAIT`**:
  - `pairValid`=0.
  - On `resultValid`: if `resultHit`, increment `hitCount` (saturating). Then advance the pair.
  - `resultValid` is ignored in any state other than `WAIT`.
- **Pair advance**:
  - If j<N-1: j=j+1.
  - Else if i<N-2: i=i+1, j=i+2 (using the old i).
  - Else the last pair (N-2,N-1) has finished: go to `DONE`.
  - Otherwise return to `ISSUE`.
- **`DONE`**: `frameDone`=1 for one cycle, then go to `IDLE`. `hitCount` holds its value until the next accepted `frameStart`.
- **`frameStart` while not in `IDLE`** (including `DONE`): ignored and sets `overrun`. Only `reset` clears `overrun`.
- **Reset values**: state=`IDLE`; `pairValid`=0, `pairIdxA`=0, `pairIdxB`=1, `busy`=0, `frameDone`=0, `hitCount`=0, `overrun`=0; snapshot=0; cooldown mask=0.
- **Reset mid-scan**: immediate abort and return to the reset values. The engine must tolerate an abandoned request.

## Timing
- `frameStart` at cycle T (in `IDLE`):
  - `busy`=1 at T+1;
  - the first eligible `pairValid` at T+1+(number of skipped pairs before it).
- Issuing a pair takes ≥1 cycle in `ISSUE`, plus engine latency in `WAIT`.
- The next pair is evaluated the cycle after the `resultValid` cycle.
- `frameDone` asserts the cycle after the last pair completes or is skipped.
- Full all-skip scan: N(N-1)/2 `ISSUE` cycles + 1 `DONE` cycle.
- Outputs are registered. No combinational path from `pairReady` to `pairValid`.

## Configuration
- Macro **`PAIR_COOLDOWN_EN`**.
- Defined:
  - keep a N(N-1)/2-bit per-pair mask;
  - a pair that reported `resultHit`=1 sets its bit;
  - in the next scan that pair is skipped once (treated as ineligible) and its bit is cleared at that skip;
  - this prevents double-reflection while balls still overlap;
  - `reset` clears the mask.
- Undefined: no mask; every active pair is issued every scan.

## Test plan
- N=4, all active, `pairReady` tied 1, engine replies with `resultHit`=0 two cycles after acceptance → pairs issued in the order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3); one `frameDone` pulse; `hitCount`=0.
- `pairReady` held low for 5 cycles on pair (0,2) → `pairValid` and indices stay stable for all 5 cycles; no advance until the handshake.
- `ballActive`=4'b1101 (ball 1 inactive) → only pairs (0,2),(0,3),(2,3) issued; scan length includes 3 skip cycles.
- Hits reported on (0,1) and (2,3) → `hitCount`=2 after `frameDone`. With `PAIR_COOLDOWN_EN`: the next scan skips those two pairs, and the scan after that issues all six again.
- `frameStart` pulsed while `WAIT` → scan unaffected; `overrun`=1 and stays 1 until `reset`.
- `reset` asserted during `WAIT` on pair (1,2) → all outputs return to reset values immediately; the next `frameStart` restarts the scan at (0,1).
